snake_body: RTL

Consumer of the direction code produced by the key-direction FSM. On each move tick it steps the snake head one cell in the current direction and shifts the body trail behind it. It tracks length, grows on a food event, and detects wall and self collisions. It also answers a per-cell occupancy query for the display scanner, and sits between the direction FSM and the VGA/LED renderer.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/snake_next_head.sv | 43 ++++
 rtl/snake_body.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: direction codes, grid coordinates, body FSM states.
// Coordinate fields are sized for grids up to 16x16; larger grids need wider fields here.
package snake_pkg;

    localparam int COORD_XW = 4;
    localparam int COORD_YW = 4;

    typedef enum logic [1:0] {
        LEFT  = 2'b00,
        RIGHT = 2'b01,
        UP    = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    typedef struct packed {
        logic [COORD_XW-1:0] x;
        logic [COORD_YW-1:0] y;
    } coord_t;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_t;

endpackage

// File: rtl/snake_next_head.sv
// Combinational one-cell step of the head in a direction, with out-of-bounds detect.
// SNAKE_WRAP_EN: wrap coordinates modulo the grid instead of flagging out-of-bounds.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16
) (
    input  coord_t head,
    input  dir_t   dir,
    output coord_t nxt,
    output logic   oob
);

    // One extra bit so -1 and GRID_W/GRID_H are distinguishable from legal cells
    logic [COORD_XW:0] x_ext, nx;
    logic [COORD_YW:0] y_ext, ny;

    always_comb begin
        x_ext = {1'b0, head.x};
        y_ext = {1'b0, head.y};
        nx    = x_ext;
        ny    = y_ext;
        case (dir)
            LEFT:    nx = x_ext - (COORD_XW+1)'(1);
            RIGHT:   nx = x_ext + (COORD_XW+1)'(1);
            UP:      ny = y_ext - (COORD_YW+1)'(1);
            default: ny = y_ext + (COORD_YW+1)'(1);
        endcase
`ifdef SNAKE_WRAP_EN
        if (nx == '1)                          nx = (COORD_XW+1)'(GRID_W - 1);
        else if (nx == (COORD_XW+1)'(GRID_W))  nx = '0;
        if (ny == '1)                          ny = (COORD_YW+1)'(GRID_H - 1);
        else if (ny == (COORD_YW+1)'(GRID_H))  ny = '0;
        oob = 1'b0;
`else
        oob = (nx >= (COORD_XW+1)'(GRID_W)) || (ny >= (COORD_YW+1)'(GRID_H));
`endif
        nxt.x = nx[COORD_XW-1:0];
        nxt.y = ny[COORD_YW-1:0];
    end

endmodule

// File: rtl/snake_body.sv
// Snake body: head stepping, trail shift, growth, wall/self collision and cell query.
// SNAKE_WRAP_EN (see snake_next_head) turns walls into wrap-around edges.
module snake_body
    import snake_pkg::*;
#(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int MAX_LEN   = 16,
    parameter int START_X   = 4,
    parameter int START_Y   = 8,
    parameter int START_LEN = 3,
    localparam int CW = $clog2(GRID_W),
    localparam int RW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic [3:0]    dir,
    input  logic          grow,
    input  logic          restart,
    input  logic [CW-1:0] query_x,
    input  logic [RW-1:0] query_y,
    output logic          query_hit,
    output logic [CW-1:0] head_x,
    output logic [RW-1:0] head_y,
    output logic [LW-1:0] len,
    output logic          alive,
    output logic          collide_wall,
    output logic          collide_self
);

    coord_t        seg_q [MAX_LEN];
    coord_t        seg_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    logic          grow_pend_q, grow_pend_d;
    logic          cw_q, cw_d;
    logic          cs_q, cs_d;
    state_t        state_q, state_d;

    coord_t        nxt, qcell;
    logic          oob, self_hit, grow_now;
    logic [LW-1:0] hit_lim;
    logic          unused_dir_hi;

    assign unused_dir_hi = ^dir[3:2];

    // Entries past the start length pile up on the tail cell
    function automatic coord_t start_cell(input int i);
        coord_t c;
        int     k;
        k   = (i < START_LEN) ? i : START_LEN - 1;
        c.x = COORD_XW'(START_X - k);
        c.y = COORD_YW'(START_Y);
        return c;
    endfunction

    snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next (
        .head (seg_q[0]),
        .dir  (dir_t'(dir[1:0])),
        .nxt  (nxt),
        .oob  (oob)
    );

    // On a non-growing move the tail cell is vacated, so it is excluded
    always_comb begin
        grow_now = grow_pend_q | grow;
        hit_lim  = grow_now ? len_q : len_q - LW'(1);
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < hit_lim && seg_q[i] == nxt) self_hit = 1'b1;
    end

    always_comb begin
        qcell.x   = COORD_XW'(query_x);
        qcell.y   = COORD_YW'(query_y);
        query_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < len_q && seg_q[i] == qcell) query_hit = 1'b1;
    end

    always_comb begin
        seg_d       = seg_q;
        len_d       = len_q;
        grow_pend_d = grow_pend_q;
        cw_d        = cw_q;
        cs_d        = cs_q;
        state_d     = state_q;
        if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) seg_d[i] = start_cell(i);
            len_d       = LW'(START_LEN);
            grow_pend_d = 1'b0;
            cw_d        = 1'b0;
            cs_d        = 1'b0;
            state_d     = RUN;
        end else if (state_q == RUN) begin
            if (tick) begin
                if (oob) begin
                    cw_d    = 1'b1;
                    state_d = DEAD;
                end else if (self_hit) begin
                    cs_d    = 1'b1;
                    state_d = DEAD;
                end else begin
                    seg_d[0] = nxt;
                    for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
                    if (grow_now && len_q < LW'(MAX_LEN)) len_d = len_q + LW'(1);
                    grow_pend_d = 1'b0;
                end
            end else if (grow) begin
                grow_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= start_cell(i);
            len_q       <= LW'(START_LEN);
            grow_pend_q <= 1'b0;
            cw_q        <= 1'b0;
            cs_q        <= 1'b0;
            state_q     <= RUN;
        end else begin
            seg_q       <= seg_d;
            len_q       <= len_d;
            grow_pend_q <= grow_pend_d;
            cw_q        <= cw_d;
            cs_q        <= cs_d;
            state_q     <= state_d;
        end
    end

    assign head_x       = CW'(seg_q[0].x);
    assign head_y       = RW'(seg_q[0].y);
    assign len          = len_q;
    assign alive        = (state_q == RUN);
    assign collide_wall = cw_q;
    assign collide_self = cs_q;

endmodule
